// File: rtl/sorted_insert_writer.sv
// sorted_insert_writer: inserts D into a sorted RAM, shifting out-ranked entries up one slot (SORTED_INSERT_DESC_EN: descending order)
module sorted_insert_writer #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] D,
    input  logic [DATA_W-1:0] ram_out,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              full
);
    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_READ, S_WAIT1, S_WAIT2, S_SHIFT, S_PLACE, S_DONE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_address, w_address_nxt;
    logic [DATA_W-1:0]   r_data, w_data_nxt;
    logic                r_wren, w_wren_nxt;
    logic [ADDR_W:0]     r_count, w_count_nxt;
    logic                r_done, w_done_nxt;
    logic                r_full, w_full_nxt;
    logic [DATA_W-1:0]   r_dq, w_dq_nxt;
    logic [ADDR_W-1:0]   r_j, w_j_nxt;
    logic [ADDR_W-1:0]   r_slot, w_slot_nxt;
    logic                w_shift;
    logic                w_is_full;

`ifdef SORTED_INSERT_DESC_EN
    assign w_shift = ram_out < r_dq;
`else
    assign w_shift = ram_out > r_dq;
`endif
    assign w_is_full = r_count == (ADDR_W+1)'(DEPTH);

    assign address = r_address;
    assign data    = r_data;
    assign wren    = r_wren;
    assign count   = r_count;
    assign done    = r_done;
    assign full    = r_full;

    // State and datapath registers; reset aborts any insert and logically empties the RAM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_address <= '0;
            r_data    <= '0;
            r_wren    <= 1'b0;
            r_count   <= '0;
            r_done    <= 1'b0;
            r_full    <= 1'b0;
            r_dq      <= '0;
            r_j       <= '0;
            r_slot    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_address <= w_address_nxt;
            r_data    <= w_data_nxt;
            r_wren    <= w_wren_nxt;
            r_count   <= w_count_nxt;
            r_done    <= w_done_nxt;
            r_full    <= w_full_nxt;
            r_dq      <= w_dq_nxt;
            r_j       <= w_j_nxt;
            r_slot    <= w_slot_nxt;
        end
    end

    // Next-state: scan downward from the top entry until one no longer out-ranks Dq
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = start ? S_CHECK : S_IDLE;
            S_CHECK: w_state_nxt = w_is_full ? S_DONE : (r_count == '0) ? S_PLACE : S_READ;
            S_READ:  w_state_nxt = S_WAIT1;
            S_WAIT1: w_state_nxt = S_WAIT2;
            S_WAIT2: w_state_nxt = w_shift ? S_SHIFT : S_PLACE;
            S_SHIFT: w_state_nxt = (r_j == '0) ? S_PLACE : S_READ;
            S_PLACE: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_DONE : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs: write enable is a one-cycle pulse raised only by SHIFT and PLACE
    always_comb begin
        w_address_nxt = r_address;
        w_data_nxt    = r_data;
        w_wren_nxt    = 1'b0;
        w_count_nxt   = r_count;
        w_done_nxt    = r_done;
        w_full_nxt    = r_full;
        w_dq_nxt      = r_dq;
        w_j_nxt       = r_j;
        w_slot_nxt    = r_slot;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_dq_nxt   = D;
                    w_full_nxt = 1'b0;
                end
            end
            S_CHECK: begin
                if (w_is_full) begin
                    w_full_nxt = 1'b1;
                    w_done_nxt = 1'b1;
                end else if (r_count == '0) begin
                    w_slot_nxt = '0;
                end else begin
                    w_j_nxt = ADDR_W'(r_count - 1'b1);
                end
            end
            S_READ: w_address_nxt = r_j;
            S_WAIT2: begin
                if (!w_shift) w_slot_nxt = r_j + 1'b1;
            end
            S_SHIFT: begin
                w_address_nxt = r_j + 1'b1;
                w_data_nxt    = ram_out;
                w_wren_nxt    = 1'b1;
                w_slot_nxt    = '0;
                w_j_nxt       = (r_j == '0) ? r_j : r_j - 1'b1;
            end
            S_PLACE: begin
                w_address_nxt = r_slot;
                w_data_nxt    = r_dq;
                w_wren_nxt    = 1'b1;
                w_count_nxt   = r_count + 1'b1;
                w_done_nxt    = 1'b1;
            end
            S_DONE: begin
                if (!start) w_done_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    // Only SHIFT and PLACE may launch a RAM write
    always_ff @(posedge clk) begin
        if (!reset && r_state inside {S_IDLE, S_CHECK, S_WAIT1, S_WAIT2, S_DONE})
            assert (!w_wren_nxt);
    end
endmodule

// File: tb/tb_sorted_insert_writer.sv
// tb_sorted_insert_writer: drives sorted_insert_writer against a behavioural RAM and a sorted-list model
module tb_sorted_insert_writer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] D = '0;
    logic [7:0] ram_out;
    logic [4:0] address;
    logic [7:0] data;
    logic       wren;
    logic [5:0] count;
    logic       done;
    logic       full;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem [32];
    logic [12:0] wlog [$];
    int          model [$];

    sorted_insert_writer dut (
        .clk(clk), .reset(reset), .start(start), .D(D), .ram_out(ram_out),
        .address(address), .data(data), .wren(wren), .count(count),
        .done(done), .full(full)
    );

    always #5 clk = ~clk;

    // RAM with registered read output; writes land on the edge where wren is seen
    always @(posedge clk) begin
        if (wren) begin
            mem[address] <= data;
            wlog.push_back({address, data});
        end
        ram_out <= mem[address];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit outranks(input int stored, input int d);
`ifdef SORTED_INSERT_DESC_EN
        return stored < d;
`else
        return stored > d;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model.delete();
        wlog.delete();
    endtask

    task automatic do_insert(input logic [7:0] d);
        int n, k, p, lat, cyc;
        bit was_full;
        logic [12:0] exp_w [$];
        n = model.size();
        k = 0;
        foreach (model[i]) if (outranks(model[i], int'(d))) k++;
        was_full = (n == 32);
        if (was_full) begin
            lat = 2;
        end else begin
            p = n - k;
            for (int i = n - 1; i >= p; i--) exp_w.push_back({5'(i + 1), 8'(model[i])});
            exp_w.push_back({5'(p), d});
            model.insert(p, int'(d));
            lat = (k == n) ? 3 + 4 * k : 6 + 4 * k;
        end
        @(negedge clk);
        start = 1'b0;
        wlog.delete();
        @(negedge clk);
        D = d;
        start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 400);
        chk("latency", cyc, lat);
        chk("done_high", done, 1'b1);
        start = 1'b0;
        @(negedge clk);
        chk("done_drop", done, 1'b0);
        chk("count", count, model.size());
        chk("full", full, was_full);
        chk("num_writes", wlog.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wlog.size(); i++)
            chk($sformatf("write%0d", i), wlog[i], exp_w[i]);
        foreach (model[i]) chk($sformatf("ram[%0d]", i), mem[i], model[i]);
    endtask

    initial begin
        logic [7:0] exp3 [3];
        foreach (mem[i]) mem[i] = '0;
        // reset state
        do_reset();
        chk("rst_count", count, 0);
        chk("rst_wren", wren, 0);
        chk("rst_done", done, 0);
        chk("rst_full", full, 0);
        chk("rst_address", address, 0);
        // empty RAM single insert
        do_insert(8'd41);
        // ordered middle insert
        do_reset();
        do_insert(8'd10);
        do_insert(8'd30);
        do_insert(8'd20);
`ifdef SORTED_INSERT_DESC_EN
        exp3 = '{8'd30, 8'd20, 8'd10};
`else
        exp3 = '{8'd10, 8'd20, 8'd30};
`endif
        for (int i = 0; i < 3; i++) chk($sformatf("three_ram[%0d]", i), mem[i], exp3[i]);
        // insert below everything
        do_insert(8'd5);
        // random fill with duplicates until full
        while (model.size() < 32) do_insert(8'($urandom_range(0, 63)));
        // rejected insert on full RAM
        do_insert(8'd99);
        // reset mid-scan (in WAIT2)
        do_reset();
        do_insert(8'd10);
        do_insert(8'd30);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        D = 8'd5;
        start = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_wren", wren, 0);
        chk("abort_count", count, 0);
        chk("abort_done", done, 0);
        chk("abort_address", address, 0);
        reset = 1'b0;
        start = 1'b0;
        model.delete();
        do_insert(8'd77);
        // random inserts from empty including extremes
        do_reset();
        do_insert(8'd255);
        do_insert(8'd0);
        repeat (10) do_insert(8'($urandom_range(0, 255)));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
